// File: rtl/led_phase_sequencer.sv
// led_phase_sequencer: free-running RED/IR frame scheduler with settle, box-average and per-frame valid strobe.
// Optional ambient (dark) phase when LED_PHASE_SEQUENCER_AMBIENT_EN is defined.
module led_phase_sequencer #(
  parameter int SETTLE_CYCLES = 3,
  parameter int AVG_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] red_dc,
  input  logic [3:0] red_pga,
  input  logic [6:0] ir_dc,
  input  logic [3:0] ir_pga,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
  output logic [7:0] AMB_ADC_Value,
`endif
  output logic       frame_valid,
  output logic       busy
);
  localparam int N = 1 << AVG_LOG2;
  localparam int AW = 8 + AVG_LOG2;
  // Settle states are odd, sample states even and nonzero.
  typedef enum logic [2:0] {
    IDLE, RED_SETTLE, RED_SAMPLE, IR_SETTLE, IR_SAMPLE
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
    , AMB_SETTLE, AMB_SAMPLE
`endif
  } state_t;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
  localparam state_t LAST = AMB_SAMPLE;
`else
  localparam state_t LAST = IR_SAMPLE;
`endif
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [7:0] avg;
  logic [6:0] rdc_q, rdc_d, idc_q, idc_d, dc_d;
  logic [3:0] rpg_q, rpg_d, ipg_q, ipg_d, pga_d;
  logic [7:0] red_val_d, ir_val_d;
  logic is_settle, is_sample, settle_done, sample_done, frame_end, relatch, wr;
  logic led_red_d, led_ir_d, amb_d, fv_d, busy_d;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
  logic [7:0] amb_val_d;
`endif

  assign is_settle = state_q[0];
  assign is_sample = !state_q[0] && state_q != IDLE;
  assign settle_done = is_settle && cnt_q == 5'(SETTLE_CYCLES - 1);
  assign sample_done = is_sample && cnt_q == 5'(N - 1);
  assign frame_end = sample_done && state_q == LAST;
  assign sum = acc_q + AW'(ADC);
  assign avg = 8'(sum >> AVG_LOG2);

  always_ff @(posedge CLK)
    state_q <= rst ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE || frame_end) state_d = en ? RED_SETTLE : IDLE;
    else if (!en) state_d = IDLE;
    else if (settle_done || sample_done) state_d = state_t'(state_q + 3'd1);
  end

  always_comb begin
    relatch = state_d == RED_SETTLE && state_q != RED_SETTLE;
    rdc_d = relatch ? red_dc : rdc_q;
    rpg_d = relatch ? red_pga : rpg_q;
    idc_d = relatch ? ir_dc : idc_q;
    ipg_d = relatch ? ir_pga : ipg_q;
    cnt_d = (state_d != state_q || state_q == IDLE) ? 5'd0 : cnt_q + 5'd1;
    acc_d = (is_sample && !sample_done) ? sum : '0;
    led_red_d = state_d == RED_SETTLE || state_d == RED_SAMPLE;
    led_ir_d = state_d == IR_SETTLE || state_d == IR_SAMPLE;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
    amb_d = state_d == AMB_SETTLE || state_d == AMB_SAMPLE;
`else
    amb_d = 1'b0;
`endif
    dc_d = led_red_d ? rdc_d : led_ir_d ? idc_d : 7'd0;
    pga_d = led_red_d ? rpg_d : (led_ir_d || amb_d) ? ipg_d : 4'd0;
    wr = sample_done && (frame_end || en);
    red_val_d = (wr && state_q == RED_SAMPLE) ? avg : RED_ADC_Value;
    ir_val_d = (wr && state_q == IR_SAMPLE) ? avg : IR_ADC_Value;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
    amb_val_d = (wr && state_q == AMB_SAMPLE) ? avg : AMB_ADC_Value;
`endif
    fv_d = frame_end;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      rdc_q <= '0;
      rpg_q <= '0;
      idc_q <= '0;
      ipg_q <= '0;
      LED_RED <= 1'b0;
      LED_IR <= 1'b0;
      DC_Comp <= '0;
      PGA_Gain <= '0;
      RED_ADC_Value <= '0;
      IR_ADC_Value <= '0;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
      AMB_ADC_Value <= '0;
`endif
      frame_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rdc_q <= rdc_d;
      rpg_q <= rpg_d;
      idc_q <= idc_d;
      ipg_q <= ipg_d;
      LED_RED <= led_red_d;
      LED_IR <= led_ir_d;
      DC_Comp <= dc_d;
      PGA_Gain <= pga_d;
      RED_ADC_Value <= red_val_d;
      IR_ADC_Value <= ir_val_d;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
      AMB_ADC_Value <= amb_val_d;
`endif
      frame_valid <= fv_d;
      busy <= busy_d;
    end
  end
endmodule

// File: tb/tb_led_phase_sequencer.sv
// tb_led_phase_sequencer: frame-position model plus directed checks for led_phase_sequencer.
module tb_led_phase_sequencer;
  localparam int S = 3;
  localparam int L = 2;
  localparam int P = S + (1 << L);
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
  localparam int NPH = 3;
  localparam int FLIT = 21;
`else
  localparam int NPH = 2;
  localparam int FLIT = 14;
`endif
  localparam int F = NPH * P;

  logic CLK = 1'b0;
  logic rst, en;
  logic [6:0] red_dc, ir_dc;
  logic [3:0] red_pga, ir_pga;
  logic [7:0] ADC;
  logic LED_RED, LED_IR, frame_valid, busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
  logic [7:0] AMB_ADC_Value;
`endif

  led_phase_sequencer #(.SETTLE_CYCLES(S), .AVG_LOG2(L)) dut (
    .CLK(CLK), .rst(rst), .en(en),
    .red_dc(red_dc), .red_pga(red_pga), .ir_dc(ir_dc), .ir_pga(ir_pga), .ADC(ADC),
    .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
    .AMB_ADC_Value(AMB_ADC_Value),
`endif
    .frame_valid(frame_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0, fails = 0, cyc = 0;
  bit m_run, m_fv;
  int m_pos, m_sum;
  int m_res [3];
  int s_rdc, s_idc, s_rpg, s_ipg;
  int mode;
  int a_red, a_ir, a_amb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: position within the frame decides phase, settle vs sample and results.
  always @(posedge CLK) begin
    int ph, k;
    bit last;
    cyc++;
    m_fv = 0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_sum = 0;
      m_res = '{0, 0, 0};
      s_rdc = 0; s_idc = 0; s_rpg = 0; s_ipg = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_pos = 0; m_sum = 0;
        s_rdc = red_dc; s_idc = ir_dc; s_rpg = red_pga; s_ipg = ir_pga;
      end
    end else begin
      ph = m_pos / P;
      k = m_pos % P;
      last = m_pos == F - 1;
      if (!en && !last) m_run = 0;
      else begin
        if (k >= S) m_sum += int'(ADC);
        if (k == P - 1) begin
          m_res[ph] = m_sum >> L;
          m_sum = 0;
        end
        if (last) begin
          m_fv = 1;
          m_pos = 0;
          if (en) begin
            m_sum = 0;
            s_rdc = red_dc; s_idc = ir_dc; s_rpg = red_pga; s_ipg = ir_pga;
          end else m_run = 0;
        end else m_pos++;
      end
    end
  end

  always @(negedge CLK) begin
    int ph;
    if (cyc > 0) begin
      ph = m_run ? m_pos / P : -1;
      chk("led_red", LED_RED, ph == 0);
      chk("led_ir", LED_IR, ph == 1);
      chk("dc_comp", DC_Comp, ph == 0 ? s_rdc : ph == 1 ? s_idc : 0);
      chk("pga_gain", PGA_Gain, ph == 0 ? s_rpg : ph >= 1 ? s_ipg : 0);
      chk("red_val", RED_ADC_Value, m_res[0]);
      chk("ir_val", IR_ADC_Value, m_res[1]);
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
      chk("amb_val", AMB_ADC_Value, m_res[2]);
`endif
      chk("frame_valid", frame_valid, m_fv);
      chk("busy", busy, m_run);
    end
  end

  function automatic logic [7:0] adc_for();
    int ph, k;
    if (!m_run) return 8'(a_red);
    ph = m_pos / P;
    k = m_pos % P;
    if (mode == 1 && ph == 0 && k >= S) return 8'(k - S + 1);
    return 8'(ph == 0 ? a_red : ph == 1 ? a_ir : a_amb);
  endfunction

  task automatic tick();
    @(negedge CLK);
    ADC = adc_for();
  endtask

  task automatic wait_fv(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_valid && n < bound);
    chk("fv_seen", frame_valid, 1);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 100 && !(m_run && m_pos == p); i++) tick();
    chk("pos_reached", m_run && m_pos == p, 1);
  endtask

  initial begin
    int n, c1;
    rst = 1; en = 0; mode = 0;
    a_red = 100; a_ir = 200; a_amb = 40;
    red_dc = 7'd5; red_pga = 4'd3; ir_dc = 7'd20; ir_pga = 4'd7; ADC = 8'd0;
    repeat (3) tick();
    chk("rst_led_red", LED_RED, 0);
    chk("rst_dc", DC_Comp, 0);
    chk("rst_red_val", RED_ADC_Value, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    tick();
    en = 1;
    wait_fv(40, n);
    c1 = cyc;
    chk("lit_red100", RED_ADC_Value, 100);
    chk("lit_ir200", IR_ADC_Value, 200);
`ifdef LED_PHASE_SEQUENCER_AMBIENT_EN
    chk("lit_amb40", AMB_ADC_Value, 40);
`endif
    chk("lit_dc_red5", DC_Comp, 5);
    wait_pos(P + S);
    red_dc = 7'd9;
    chk("lit_dc_ir", DC_Comp, 20);
    tick();
    chk("lit_dc_ir_hold", DC_Comp, 20);
    wait_fv(40, n);
    chk("lit_frame_len", cyc - c1, FLIT);
    chk("lit_dc_red9", DC_Comp, 9);
    mode = 1;
    wait_fv(40, n);
    chk("lit_red_avg2", RED_ADC_Value, 2);
    mode = 0;
    a_red = 255;
    wait_fv(40, n);
    chk("lit_red255", RED_ADC_Value, 255);
    chk("lit_ir_keep200", IR_ADC_Value, 200);
    wait_pos(P + 1);
    en = 0;
    tick();
    chk("abort_led_ir", LED_IR, 0);
    chk("abort_dc", DC_Comp, 0);
    chk("abort_pga", PGA_Gain, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ir_keep", IR_ADC_Value, 200);
    repeat (5) begin
      tick();
      chk("abort_no_fv", frame_valid, 0);
    end
    en = 1;
    wait_pos(S + 1);
    rst = 1;
    tick();
    chk("rst_mid_led", LED_RED, 0);
    chk("rst_mid_red_val", RED_ADC_Value, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 0;
    wait_fv(40, n);
    chk("lit_restart_len", n, FLIT + 1);
    chk("lit_restart_red", RED_ADC_Value, 255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
